lc3_int_ctrl: RTL and testbench

- Parametrised interrupt controller for the LC-3 system.
- Collects NUM_SRC device interrupt lines. Each line can be edge- or level-sensitive and has its own enable and priority.
- Selects the highest-priority pending source whose priority is strictly greater than the CPU's current PSR priority, then presents req/priority/vector to the FSM.
- Clears edge-pending state on the FSM's vector-load acknowledge. Sits between the peripherals (buttons, I2C, timers) and the CPU/FSM interrupt inputs.

---
 rtl/lc3_int_pkg.sv | 25 ++
 rtl/lc3_int_prio_sel.sv | 38 +++
 rtl/lc3_int_ctrl.sv | 152 +++++++++++++++
 tb/tb_lc3_int_ctrl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/lc3_int_pkg.sv
// ----------------------------------------------------------------------------
// lc3_int_pkg : shared types and defaults for the LC-3 interrupt controller
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package lc3_int_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  localparam int          DEF_PRIO_W   = 3;
  localparam logic [7:0]  DEF_VEC_BASE = 8'h80;

  // Index width that stays at least one bit wide for a single source.
  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/lc3_int_prio_sel.sv
// ----------------------------------------------------------------------------
// lc3_int_prio_sel : eligible mask -> highest-priority winner (lowest index on tie)
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module lc3_int_prio_sel
  import lc3_int_pkg::*;
#(
  parameter int NUM_SRC = 8,
  parameter int PRIO_W  = DEF_PRIO_W
) (
  input  logic [NUM_SRC-1:0]             elig_i,
  input  logic [NUM_SRC-1:0][PRIO_W-1:0] prio_i,
  output logic [idx_w(NUM_SRC)-1:0]      win_idx_o,
  output logic [PRIO_W-1:0]              win_prio_o,
  output logic                           any_o
);

  localparam int IDX_W = idx_w(NUM_SRC);

  // Strict greater-than keeps the earlier (lower) index on equal priority.
  always_comb begin
    win_idx_o  = '0;
    win_prio_o = '0;
    any_o      = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (elig_i[i] && (!any_o || (prio_i[i] > win_prio_o))) begin
        win_idx_o  = IDX_W'(i);
        win_prio_o = prio_i[i];
        any_o      = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/lc3_int_ctrl.sv
// ----------------------------------------------------------------------------
// lc3_int_ctrl : LC-3 interrupt controller (sync, pending, selection, req FSM)
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module lc3_int_ctrl
  import lc3_int_pkg::*;
#(
  parameter int                   NUM_SRC   = 8,
  parameter int                   PRIO_W    = DEF_PRIO_W,
  parameter int                   VEC_W     = 8,
  parameter logic [VEC_W-1:0]     VEC_BASE  = VEC_W'(DEF_VEC_BASE),
  parameter logic [NUM_SRC-1:0]   EDGE_MASK = {NUM_SRC{1'b1}}
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_SRC-1:0]         irq_i,
  input  logic                       cfg_we_i,
  input  logic [idx_w(NUM_SRC)-1:0]  cfg_sel_i,
  input  logic                       cfg_en_i,
  input  logic [PRIO_W-1:0]          cfg_prio_i,
  input  logic [PRIO_W-1:0]          cpu_priority_i,
  input  logic                       int_ack_i,
  output logic                       int_req_o,
  output logic [PRIO_W-1:0]          int_priority_o,
  output logic [VEC_W-1:0]           int_vector_o,
  output logic [NUM_SRC-1:0]         pending_o
);

  localparam int IDX_W = idx_w(NUM_SRC);

  logic [NUM_SRC-1:0]             sync1_q, sync2_q, sync3_q;
  logic [NUM_SRC-1:0]             pending_q, pending_d;
  logic [NUM_SRC-1:0]             en_q;
  logic [NUM_SRC-1:0][PRIO_W-1:0] prio_q;
  logic [NUM_SRC-1:0]             elig;

  state_e                         state_q;
  logic [IDX_W-1:0]               win_idx_q;
  logic [PRIO_W-1:0]              win_prio_q;
  logic                           int_req_q;
  logic [VEC_W-1:0]               int_vector_q;

  logic [IDX_W-1:0]               sel_idx;
  logic [PRIO_W-1:0]              sel_prio;
  logic                           sel_any;
  logic                           ack_fire;

  assign ack_fire = (state_q == ST_REQ) && int_ack_i;

  always_comb begin
    elig = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      elig[i] = pending_q[i] & en_q[i] & (prio_q[i] > cpu_priority_i);
    end
  end

  // A fresh edge in the ack cycle re-arms the source rather than being lost.
  always_comb begin
    pending_d = pending_q;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (EDGE_MASK[i]) begin
        pending_d[i] = (sync2_q[i] & ~sync3_q[i]) |
                       (pending_q[i] & ~(ack_fire && (win_idx_q == IDX_W'(i))));
      end else begin
        pending_d[i] = sync2_q[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      sync3_q   <= '0;
      pending_q <= '0;
      en_q      <= '0;
      prio_q    <= '0;
    end else begin
      sync1_q   <= irq_i;
      sync2_q   <= sync1_q;
      sync3_q   <= sync2_q;
      pending_q <= pending_d;
      for (int i = 0; i < NUM_SRC; i++) begin
        if (cfg_we_i && (cfg_sel_i == IDX_W'(i))) begin
          en_q[i]   <= cfg_en_i;
          prio_q[i] <= cfg_prio_i;
        end
      end
    end
  end

  lc3_int_prio_sel #(
    .NUM_SRC (NUM_SRC),
    .PRIO_W  (PRIO_W)
  ) u_prio_sel (
    .elig_i     (elig),
    .prio_i     (prio_q),
    .win_idx_o  (sel_idx),
    .win_prio_o (sel_prio),
    .any_o      (sel_any)
  );

  // The presented source is frozen for the whole REQ state; no preemption.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      win_idx_q    <= '0;
      win_prio_q   <= '0;
      int_req_q    <= 1'b0;
      int_vector_q <= VEC_BASE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (sel_any) begin
            state_q      <= ST_REQ;
            win_idx_q    <= sel_idx;
            win_prio_q   <= sel_prio;
            int_vector_q <= VEC_BASE + VEC_W'(sel_idx);
            int_req_q    <= 1'b1;
          end
        end
        ST_REQ: begin
          if (int_ack_i) begin
            state_q   <= ST_HOLD;
            int_req_q <= 1'b0;
          end else if (!elig[win_idx_q]) begin
            state_q   <= ST_IDLE;
            int_req_q <= 1'b0;
          end
        end
        ST_HOLD: begin
          state_q   <= ST_IDLE;
          int_req_q <= 1'b0;
        end
        default: begin
          state_q   <= ST_IDLE;
          int_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign int_req_o      = int_req_q;
  assign int_priority_o = win_prio_q;
  assign int_vector_o   = int_vector_q;
  assign pending_o      = pending_q;

endmodule

`default_nettype wire

// File: tb/tb_lc3_int_ctrl.sv
// ----------------------------------------------------------------------------
// tb_lc3_int_ctrl : directed self-checking bench for lc3_int_ctrl
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_lc3_int_ctrl;

  logic       clk;
  logic       rst_n;
  logic [7:0] irq;
  logic       cfg_we;
  logic [2:0] cfg_sel;
  logic       cfg_en;
  logic [2:0] cfg_prio;
  logic [2:0] cpu_priority;
  logic       int_ack;
  logic       int_req;
  logic [2:0] int_priority;
  logic [7:0] int_vector;
  logic [7:0] pending;

  int vectors;
  int miscompares;

  lc3_int_ctrl #(
    .NUM_SRC   (8),
    .PRIO_W    (3),
    .VEC_W     (8),
    .VEC_BASE  (8'h80),
    .EDGE_MASK (8'hFE)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .irq_i          (irq),
    .cfg_we_i       (cfg_we),
    .cfg_sel_i      (cfg_sel),
    .cfg_en_i       (cfg_en),
    .cfg_prio_i     (cfg_prio),
    .cpu_priority_i (cpu_priority),
    .int_ack_i      (int_ack),
    .int_req_o      (int_req),
    .int_priority_o (int_priority),
    .int_vector_o   (int_vector),
    .pending_o      (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cfg(input logic [2:0] sel, input logic en, input logic [2:0] prio);
    cfg_we   = 1'b1;
    cfg_sel  = sel;
    cfg_en   = en;
    cfg_prio = prio;
    tick(1);
    cfg_we   = 1'b0;
  endtask

  // One-cycle irq pulse; the sampling edge is the first posedge of this call.
  task automatic pulse(input int bit_i);
    irq[bit_i] = 1'b1;
    tick(1);
    irq[bit_i] = 1'b0;
  endtask

  // Ack, check the HOLD cycle, then leave the bench on the cycle a new REQ could appear.
  task automatic do_ack(input string tag);
    int_ack = 1'b1;
    tick(1);
    int_ack = 1'b0;
    check({tag, "_hold_req"}, 32'(int_req), 32'd0);
    tick(2);
  endtask

  initial begin
    vectors      = 0;
    miscompares  = 0;
    rst_n        = 1'b0;
    irq          = 8'h00;
    cfg_we       = 1'b0;
    cfg_sel      = 3'd0;
    cfg_en       = 1'b0;
    cfg_prio     = 3'd0;
    cpu_priority = 3'd0;
    int_ack      = 1'b0;

    // Reset held while irq toggles
    tick(1); irq = 8'hFF;
    tick(1); irq = 8'h55;
    tick(1);
    check("rst_req",  32'(int_req),      32'd0);
    check("rst_pend", 32'(pending),      32'h00);
    check("rst_vec",  32'(int_vector),   32'h80);
    check("rst_prio", 32'(int_priority), 32'd0);
    irq = 8'h00;
    tick(2);
    rst_n = 1'b1;
    tick(1);

    // No config: edge on src7 pends but never requests
    pulse(7);
    tick(6);
    check("nocfg_pend", 32'(pending), 32'h80);
    check("nocfg_req",  32'(int_req), 32'd0);

    // Single edge source, latency
    cfg(3'd3, 1'b1, 3'd4);
    pulse(3);
    tick(2);
    check("lat_pend3", 32'(pending[3]), 32'd1);
    check("lat_req_early", 32'(int_req), 32'd0);
    tick(1);
    check("lat_req",  32'(int_req),      32'd1);
    check("lat_vec",  32'(int_vector),   32'h83);
    check("lat_prio", 32'(int_priority), 32'd4);
    int_ack = 1'b1;
    tick(1);
    int_ack = 1'b0;
    check("ack_pend3", 32'(pending[3]), 32'd0);
    check("ack_hold",  32'(int_req),    32'd0);
    tick(2);
    check("ack_after", 32'(int_req),    32'd0);

    // Priority ordering and tie-break
    cfg(3'd1, 1'b1, 3'd2);
    cfg(3'd5, 1'b1, 3'd6);
    cfg(3'd6, 1'b1, 3'd6);
    irq[1] = 1'b1; irq[5] = 1'b1; irq[6] = 1'b1;
    tick(1);
    irq[1] = 1'b0; irq[5] = 1'b0; irq[6] = 1'b0;
    tick(3);
    check("tie_req",  32'(int_req),      32'd1);
    check("tie_vec1", 32'(int_vector),   32'h85);
    check("tie_pri1", 32'(int_priority), 32'd6);
    do_ack("tie1");
    check("tie_vec2", 32'(int_vector),   32'h86);
    check("tie_req2", 32'(int_req),      32'd1);
    do_ack("tie2");
    check("tie_vec3", 32'(int_vector),   32'h81);
    check("tie_pri3", 32'(int_priority), 32'd2);
    do_ack("tie3");
    check("tie_done", 32'(int_req),      32'd0);
    check("tie_pend", 32'(pending),      32'h80);

    // CPU priority masking
    cfg(3'd2, 1'b1, 3'd3);
    cpu_priority = 3'd3;
    pulse(2);
    tick(6);
    check("mask_req",  32'(int_req),    32'd0);
    check("mask_pend", 32'(pending[2]), 32'd1);
    cpu_priority = 3'd2;
    tick(1);
    check("unmask_req",  32'(int_req),      32'd1);
    check("unmask_vec",  32'(int_vector),   32'h82);
    check("unmask_prio", 32'(int_priority), 32'd3);
    do_ack("mask");
    check("mask_done", 32'(int_req), 32'd0);
    cpu_priority = 3'd0;

    // Level source withdrawal
    cfg(3'd0, 1'b1, 3'd5);
    irq[0] = 1'b1;
    tick(4);
    check("lvl_req",  32'(int_req),    32'd1);
    check("lvl_vec",  32'(int_vector), 32'h80);
    irq[0] = 1'b0;
    tick(3);
    check("lvl_still", 32'(int_req),   32'd1);
    tick(1);
    check("lvl_drop",  32'(int_req),    32'd0);
    check("lvl_pend0", 32'(pending[0]), 32'd0);

    // New edge coincident with ack
    pulse(3);
    tick(3);
    check("sim_req", 32'(int_req), 32'd1);
    irq[3] = 1'b1;
    tick(1);
    irq[3] = 1'b0;
    tick(1);
    int_ack = 1'b1;
    tick(1);
    int_ack = 1'b0;
    check("sim_pend3", 32'(pending[3]), 32'd1);
    check("sim_hold",  32'(int_req),    32'd0);
    tick(2);
    check("sim_rereq", 32'(int_req),    32'd1);
    check("sim_vec",   32'(int_vector), 32'h83);

    // Asynchronous reset while requesting
    #2 rst_n = 1'b0;
    #1;
    check("arst_req",  32'(int_req),    32'd0);
    check("arst_pend", 32'(pending),    32'h00);
    check("arst_vec",  32'(int_vector), 32'h80);
    tick(2);
    rst_n = 1'b1;
    tick(1);
    pulse(3);
    tick(6);
    check("arst_noen", 32'(int_req), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
